loopback_sequencer: RTL and testbench

Sequences the greycode pad-loopback latency measurement. The block drives an 8-bit Gray-code pattern toward the output pads and into the comparator's expected-value input. It consumes the comparator's one-hot 4-bit latency result, and locks onto a stable round-trip latency of 1–4 cycles or declares failure. After lock it keeps running and counts latency mismatches as link errors.

---
 rtl/loopback_sequencer.sv | 157 +++++++++++++++
 tb/tb_loopback_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_sequencer.sv
// loopback_sequencer
//   Sequences the Gray-code pad-loopback latency measurement. Drives an
//   8-bit Gray pattern to the pads and the comparator's expected-value input,
//   locks onto a stable one-hot round-trip latency (1..4 cycles) or fails, and
//   counts latency mismatches as link errors once locked.
//
// Ports
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_start    start/restart request (honoured in IDLE, LOCKED, FAIL)
//   i_diff     one-hot comparator latency result, bit k = k extra cycles
//   o_out      registered Gray pattern
//   o_busy     high in PRIME and MEASURE
//   o_locked   high in LOCKED
//   o_fail     high in FAIL
//   o_lat      encoded locked latency
//   o_err_cnt  saturating mismatch count while LOCKED
module loopback_sequencer #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_diff,
  output logic [7:0] o_out,
  output logic       o_busy,
  output logic       o_locked,
  output logic       o_fail,
  output logic [1:0] o_lat,
  output logic [7:0] o_err_cnt
);

  localparam logic [7:0] LOCK_V = 8'(LOCK_CNT);
  localparam logic [7:0] TMO_V  = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_MEASURE,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t     r_state, w_state;
  logic [7:0] r_cnt,   w_cnt;
  logic [7:0] r_out;
  logic [2:0] r_prime, w_prime;
  logic [7:0] r_match, w_match;
  logic [3:0] r_cand,  w_cand;
  logic [7:0] r_tmo,   w_tmo;
  logic [1:0] r_lat,   w_lat;
  logic [7:0] r_err,   w_err;
  logic       w_onehot;

  function automatic logic [1:0] enc(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_prime  = r_prime;
    w_match  = r_match;
    w_cand   = r_cand;
    w_tmo    = r_tmo;
    w_lat    = r_lat;
    w_err    = r_err;
    w_onehot = (i_diff != 4'd0) && ((i_diff & (i_diff - 4'd1)) == 4'd0);

    case (r_state)
      S_PRIME: begin
        // Comparator pipeline still filling: i_diff ignored for 6 cycles.
        w_cnt   = r_cnt + 8'd1;
        w_prime = r_prime + 3'd1;
        if (r_prime == 3'd5) w_state = S_MEASURE;
      end
      S_MEASURE: begin
        w_cnt = r_cnt + 8'd1;
        w_tmo = r_tmo + 8'd1;
        if (!w_onehot) begin
          w_match = '0;
        end else if (i_diff == r_cand) begin
          w_match = r_match + 8'd1;
        end else begin
          w_cand  = i_diff;
          w_match = 8'd1;
        end
        // Lock wins over timeout when both land on the same cycle.
        if (w_match == LOCK_V) begin
          w_state = S_LOCKED;
          w_lat   = enc(w_cand);
        end else if (w_tmo == TMO_V) begin
          w_state = S_FAIL;
        end
      end
      S_LOCKED: begin
        w_cnt = r_cnt + 8'd1;
        if ((i_diff != r_cand) && (r_err != '1)) w_err = r_err + 8'd1;
      end
      default: ;
    endcase

    if (i_start && ((r_state == S_IDLE) || (r_state == S_LOCKED) ||
                    (r_state == S_FAIL))) begin
      w_state = S_PRIME;
      w_cnt   = '0;
      w_prime = '0;
      w_match = '0;
      w_cand  = '0;
      w_tmo   = '0;
      w_lat   = '0;
      w_err   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
      r_prime <= '0;
      r_match <= '0;
      r_cand  <= '0;
      r_tmo   <= '0;
      r_lat   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      // Pattern register tracks the next count so o_out is always gray(cnt).
      r_out   <= w_cnt ^ (w_cnt >> 1);
      r_prime <= w_prime;
      r_match <= w_match;
      r_cand  <= w_cand;
      r_tmo   <= w_tmo;
      r_lat   <= w_lat;
      r_err   <= w_err;
    end
  end

  assign o_out     = r_out;
  assign o_busy    = (r_state == S_PRIME) || (r_state == S_MEASURE);
  assign o_locked  = (r_state == S_LOCKED);
  assign o_fail    = (r_state == S_FAIL);
  assign o_lat     = r_lat;
  assign o_err_cnt = r_err;

endmodule

// File: tb/tb_loopback_sequencer.sv
// tb_loopback_sequencer
//   Self-checking bench for loopback_sequencer (default LOCK_CNT=8,
//   TIMEOUT=64). A behavioural comparator model returns o_out through D
//   extra flops and reports the one-hot lag; expected pattern/error values
//   are queued on the scoreboard as stimulus is driven.
module tb_loopback_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [3:0] i_diff = 4'd0;
  logic [7:0] o_out;
  logic       o_busy;
  logic       o_locked;
  logic       o_fail;
  logic [1:0] o_lat;
  logic [7:0] o_err_cnt;

  int checks = 0;
  int failures = 0;

  int         cur_d = 0;
  bit         force_on = 1'b0;
  logic [3:0] force_val = 4'd0;
  logic [7:0] h [0:7];
  logic [7:0] exp_q [$];

  loopback_sequencer #(.LOCK_CNT(8), .TIMEOUT(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_diff(i_diff),
    .o_out(o_out), .o_busy(o_busy), .o_locked(o_locked), .o_fail(o_fail),
    .o_lat(o_lat), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Advance one cycle, record the pattern history and drive the comparator
  // result for the new cycle.
  task automatic tick();
    @(posedge i_clk);
    #1;
    for (int k = 7; k > 0; k--) h[k] = h[k-1];
    h[0] = o_out;
    if (force_on) i_diff = force_val;
    else for (int k = 0; k < 4; k++) i_diff[k] = (h[cur_d] == h[k]);
  endtask

  // Drive i_start through the sampling edge; afterwards the bench is in cycle 1.
  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_start = 1'b1;
    tick(); tick();
    checks++;
    if ({o_out, o_busy, o_locked, o_fail, o_lat, o_err_cnt} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs got out=%0h busy=%0b lock=%0b fail=%0b lat=%0d err=%0d want all 0",
               o_out, o_busy, o_locked, o_fail, o_lat, o_err_cnt);
    end
    i_rst = 1'b0;
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({o_out, o_busy, o_locked, o_fail} !== 11'd0) begin
      failures++;
      $display("FAIL idle_hold got out=%0h busy=%0b lock=%0b fail=%0b want 0",
               o_out, o_busy, o_locked, o_fail);
    end
  endtask

  task automatic test_loopback(input int d);
    logic [7:0] e;
    force_on = 1'b0;
    cur_d = d;
    exp_q.push_back(gray(8'd0));
    start_pulse();
    e = exp_q.pop_front();
    checks++;
    if (o_out !== e || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL lb%0d_cycle1 got out=%0h busy=%0b want out=%0h busy=1", d, o_out, o_busy, e);
    end
    for (int c = 2; c <= 315; c++) begin
      exp_q.push_back(gray(8'(c - 1)));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_out !== e) begin
        failures++;
        $display("FAIL lb%0d_pattern c=%0d got %0h want %0h", d, c, o_out, e);
      end
      if (c == 14) begin
        checks++;
        if (o_locked !== 1'b0 || o_busy !== 1'b1) begin
          failures++;
          $display("FAIL lb%0d_prelock got lock=%0b busy=%0b want 0/1", d, o_locked, o_busy);
        end
      end
      if (c == 15) begin
        checks++;
        if (o_locked !== 1'b1 || o_busy !== 1'b0 || o_lat !== 2'(d)) begin
          failures++;
          $display("FAIL lb%0d_lock got lock=%0b busy=%0b lat=%0d want 1/0/%0d",
                   d, o_locked, o_busy, o_lat, d);
        end
      end
    end
    checks++;
    if (o_err_cnt !== 8'd0 || o_locked !== 1'b1) begin
      failures++;
      $display("FAIL lb%0d_steady got err=%0d lock=%0b want 0/1", d, o_err_cnt, o_locked);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] e;
    force_on = 1'b1;
    force_val = 4'd0;
    start_pulse();
    for (int c = 2; c <= 71; c++) begin
      tick();
      if (c == 70) begin
        checks++;
        if (o_fail !== 1'b0 || o_busy !== 1'b1) begin
          failures++;
          $display("FAIL tmo_early got fail=%0b busy=%0b want 0/1", o_fail, o_busy);
        end
      end
    end
    checks++;
    if (o_fail !== 1'b1 || o_locked !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_fail got fail=%0b lock=%0b busy=%0b want 1/0/0", o_fail, o_locked, o_busy);
    end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(gray(8'd70));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_out !== e || o_fail !== 1'b1) begin
        failures++;
        $display("FAIL tmo_frozen got out=%0h fail=%0b want %0h/1", o_out, o_fail, e);
      end
    end
    force_on = 1'b0;
  endtask

  task automatic test_glitch();
    force_on = 1'b0;
    cur_d = 1;
    start_pulse();
    for (int c = 2; c <= 19; c++) begin
      tick();
      if (c == 10) i_diff = 4'b0000;
      if (c == 15 || c == 18) begin
        checks++;
        if (o_locked !== 1'b0) begin
          failures++;
          $display("FAIL glitch_nolock c=%0d got lock=%0b want 0", c, o_locked);
        end
      end
    end
    checks++;
    if (o_locked !== 1'b1 || o_lat !== 2'd1) begin
      failures++;
      $display("FAIL glitch_lock got lock=%0b lat=%0d want 1/1", o_locked, o_lat);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] model, e;
    force_on = 1'b0;
    cur_d = 2;
    start_pulse();
    for (int c = 2; c <= 15; c++) tick();
    checks++;
    if (o_locked !== 1'b1 || o_lat !== 2'd2) begin
      failures++;
      $display("FAIL sat_lock got lock=%0b lat=%0d want 1/2", o_locked, o_lat);
    end
    force_on = 1'b1;
    force_val = 4'b0001;
    i_diff = 4'b0001;
    model = 8'd0;
    for (int i = 0; i < 300; i++) begin
      if (model != 8'hFF) model = model + 8'd1;
      exp_q.push_back(model);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_err_cnt !== e) begin
        failures++;
        $display("FAIL sat_err i=%0d got %0d want %0d", i, o_err_cnt, e);
      end
    end
    checks++;
    if (o_locked !== 1'b1 || o_err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_final got lock=%0b err=%0d want 1/255", o_locked, o_err_cnt);
    end
    force_on = 1'b0;
  endtask

  task automatic test_start_ignored_and_restart();
    force_on = 1'b0;
    cur_d = 0;
    start_pulse();
    for (int c = 2; c <= 15; c++) begin
      tick();
      i_start = (c <= 14) ? c[0] : 1'b0;
    end
    checks++;
    if (o_locked !== 1'b1 || o_lat !== 2'd0) begin
      failures++;
      $display("FAIL ign_lock got lock=%0b lat=%0d want 1/0", o_locked, o_lat);
    end
    force_on = 1'b1;
    force_val = 4'b0010;
    i_diff = 4'b0010;
    tick(); tick(); tick();
    checks++;
    if (o_err_cnt !== 8'd3) begin
      failures++;
      $display("FAIL err_count got %0d want 3", o_err_cnt);
    end
    start_pulse();
    checks++;
    if ({o_locked, o_err_cnt, o_busy, o_out, o_lat} !== {1'b0, 8'd0, 1'b1, 8'd0, 2'd0}) begin
      failures++;
      $display("FAIL restart got lock=%0b err=%0d busy=%0b out=%0h lat=%0d want 0/0/1/0/0",
               o_locked, o_err_cnt, o_busy, o_out, o_lat);
    end
    force_on = 1'b0;
    tick();
    checks++;
    if (o_out !== gray(8'd1)) begin
      failures++;
      $display("FAIL restart_pattern got %0h want %0h", o_out, gray(8'd1));
    end
  endtask

  task automatic test_reset_mid_run();
    force_on = 1'b0;
    cur_d = 0;
    start_pulse();
    for (int c = 2; c <= 9; c++) tick();
    i_rst = 1'b1;
    i_start = 1'b1;
    tick();
    checks++;
    if ({o_out, o_busy, o_locked, o_fail, o_lat, o_err_cnt} !== 21'd0) begin
      failures++;
      $display("FAIL rst_measure got out=%0h busy=%0b lock=%0b fail=%0b want 0",
               o_out, o_busy, o_locked, o_fail);
    end
    i_rst = 1'b0;
    i_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({o_out, o_busy} !== 9'd0) begin
      failures++;
      $display("FAIL rst_idle got out=%0h busy=%0b want 0/0", o_out, o_busy);
    end
    cur_d = 3;
    start_pulse();
    for (int c = 2; c <= 15; c++) tick();
    checks++;
    if (o_locked !== 1'b1 || o_lat !== 2'd3) begin
      failures++;
      $display("FAIL rst_lock3 got lock=%0b lat=%0d want 1/3", o_locked, o_lat);
    end
    force_on = 1'b1;
    force_val = 4'b0001;
    i_diff = 4'b0001;
    tick(); tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checks++;
    if ({o_out, o_busy, o_locked, o_fail, o_lat, o_err_cnt} !== 21'd0) begin
      failures++;
      $display("FAIL rst_locked got out=%0h lock=%0b lat=%0d err=%0d want 0",
               o_out, o_locked, o_lat, o_err_cnt);
    end
    force_on = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) h[k] = 8'd0;
    test_reset();
    for (int d = 0; d < 4; d++) test_loopback(d);
    test_timeout();
    test_glitch();
    test_saturate();
    test_start_ignored_and_restart();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
